ov7670_capture: RTL and testbench
=================================

# ov7670_capture

- Captures one camera frame (OV7670, RGB444 byte stream) into frame buffer 1 as 320×240 12-bit pixels, addresses 0..76799.
- Upstream stage of the in-place frame filters: when `led_done` rises, the buffer is complete and a filter (e.g. grayscale) may be enabled.
- Single-shot: each `enable_capture` pulse while idle or done captures exactly one full frame.

## Interface
Parameters:
- `FRAME_W`, 320: stored pixels per line.
- `FRAME_H`, 240: stored lines per frame.

Ports:
- `clk_i` input 1: camera PCLK; sole clock.
- `rst_i` input 1: synchronous, active-high reset.
- `enable_capture` input 1: start request; sampled in IDLE_ST and DONE_ST.
- `cam_vsync` input 1: camera VSYNC, high between frames.
- `cam_href` input 1: camera HREF, high during active line bytes.
- `cam_data` input 8: camera data byte.
- `wraddr_buf1` output 17: buffer write address.
- `dout_buf1` output 12: pixel {R,G,B}, 4 bits each.
- `we_buf1` output 1: one-cycle write strobe per stored pixel.
- `led_done` output 1: frame stored; held until the next start.
- `frame_err` output 1: last frame pixel count ≠ FRAME_W×FRAME_H.

## Operation
- Input register stage: `cam_vsync`, `cam_href` and `cam_data` are registered once. All logic uses the registered copies (`vs_r`, `hr_r`, `d_r`).
- States:
  - IDLE_ST: wait for `enable_capture`.
  - WAIT_VS_HIGH_ST: wait until `vs_r`=1; avoids starting mid-frame.
  - WAIT_VS_LOW_ST: wait for `vs_r` 1→0; frame start.
  - CAPTURE_ST: store pixels until `vs_r` 0→1.
  - DONE_ST: finished.
- Transitions:
  - IDLE_ST/DONE_ST + `enable_capture`=1 → WAIT_VS_HIGH_ST. On this transition: clear `led_done`, `frame_err`, pixel counter, address, row/column counters and byte phase.
  - WAIT_VS_HIGH_ST → WAIT_VS_LOW_ST when `vs_r`=1.
  - WAIT_VS_LOW_ST → CAPTURE_ST on the cycle `vs_r` is sampled 0 after 1.
  - CAPTURE_ST → DONE_ST on `vs_r` 0→1. In the same cycle: `led_done`←1; `frame_err`←(pixel count ≠ FRAME_W×FRAME_H).
- Byte pairing, only in CAPTURE_ST:
  - While `hr_r`=1, the byte phase toggles every cycle.
  - Phase 0 byte → R = `d_r[3:0]` (bits 7:4 ignored).
  - Phase 1 byte → G = `d_r[7:4]`, B = `d_r[3:0]`. This completes one camera pixel.
  - The byte phase forces to 0 whenever `hr_r`=0, so an odd byte count per line never shifts the next line.
- Column counter: counts completed camera pixels in the line; clears when `hr_r`=0.
- Row counter: increments on `hr_r` 1→0; clears at frame start.
- Store rule:
  - Every completed pixel is stored, except as restricted by the decimation macro (see Configuration).
  - A store asserts `we_buf1` with `dout_buf1`={R,G,B} and `wraddr_buf1`=pixel count, then increments the pixel count.
- Overflow: once the pixel count reaches 76800, further stores are suppressed (`we_buf1` stays 0) and the count saturates at 76800. `frame_err` is then set at frame end.
- `enable_capture` outside IDLE_ST/DONE_ST is ignored.

## Timing
- Reset values: `wraddr_buf1`=0, `dout_buf1`=0, `we_buf1`=0, `led_done`=0, `frame_err`=0, state IDLE_ST, all counters 0.
- Reset mid-capture aborts at once. No further writes occur; the partial frame is left in the buffer.
- Latency from `cam_data` pin to write:
  - Edge 1: second byte of a pixel registered into `d_r`.
  - Edge 2: `we_buf1`, `dout_buf1` and `wraddr_buf1` updated, all valid in the same cycle.
- `wraddr_buf1` holds the last written address between strobes.
- `we_buf1` is never high for two consecutive cycles.
- Back-to-back pixels: one strobe every 2 cycles while `hr_r`=1.
- Simultaneous events:
  - `vs_r` 0→1 together with a completing byte: the pixel is stored, then DONE_ST.
  - `enable_capture` in DONE_ST together with `vs_r`=1: enter WAIT_VS_HIGH_ST, advance to WAIT_VS_LOW_ST next cycle.

## Configuration
- `CAPTURE_DECIMATE_EN`:
  - Defined: camera runs VGA 640×480. Store only when column counter bit0=0 and row counter bit0=0; result is 320×240.
  - Undefined: camera runs QVGA. Every completed pixel is stored.
- In both modes the address range, `frame_err` rule and overflow rule are identical.

## Structure
- Shared package `cam_pkg`:
  - `FRAME_W`, `FRAME_H`, `NUM_PIXELS`=76800.
  - 17-bit address type, 12-bit RGB444 pixel type.
  - Capture state encoding.
- One sub-module: `cam_pixel_assembler`. It contains the byte phase, R holding register and pixel-complete strobe; inputs `hr_r`, `d_r`.
- FSM, counters and write port stay in the top.

## Test plan
- Reset then idle: `we_buf1`=0 and `led_done`=0 for 1000 cycles of camera frames with `enable_capture`=0.
- Start mid-frame (`vs_r`=0 at enable): no write until the next VSYNC high→low. Exactly 76800 strobes follow; last address 76799; `led_done`=1; `frame_err`=0.
- Line of bytes 0x0A,0x5C: `dout_buf1`=0xA5C at address 0, 2 cycles after the 0x5C byte.
- Line with 641 bytes (odd count): the next line's first pixel is still paired correctly; total count ≠ 76800 → `frame_err`=1.
- 241-line frame: writes stop at address 76799; `we_buf1` stays 0 afterwards; `frame_err`=1.
- `CAPTURE_DECIMATE_EN` with 640×480 ramp pattern: address 1 holds camera pixel (row 0, col 2); address 320 holds (row 2, col 0).

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: frame geometry, pixel and
// address types, and the capture state encoding.
package cam_pkg;

    localparam int FRAME_W    = 320;
    localparam int FRAME_H    = 240;
    localparam int NUM_PIXELS = FRAME_W * FRAME_H;

    typedef logic [16:0] addr_t;
    typedef logic [11:0] pix_t;
    typedef logic [2:0]  state_t;

    localparam logic [2:0] IDLE_ST         = 3'd0;
    localparam logic [2:0] WAIT_VS_HIGH_ST = 3'd1;
    localparam logic [2:0] WAIT_VS_LOW_ST  = 3'd2;
    localparam logic [2:0] CAPTURE_ST      = 3'd3;
    localparam logic [2:0] DONE_ST         = 3'd4;

endpackage

// File: rtl/cam_pixel_assembler.sv
// Pairs RGB444 camera bytes into 12-bit pixels; the byte phase restarts at
// every line so an odd byte count never skews the following line.
module cam_pixel_assembler
    import cam_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_en,
    input  logic       i_hr,
    input  logic [7:0] i_d,
    output logic       o_pix_done,
    output pix_t       o_pix
);

    logic       r_phase;
    logic [3:0] r_red;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_phase <= 1'b0;
            r_red   <= 4'd0;
        end else if (!i_en || !i_hr) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_red <= i_d[3:0];
            end
        end
    end

    // Second byte is combined directly so the top can register the write one edge later.
    assign o_pix_done = i_en & i_hr & r_phase;
    assign o_pix      = {r_red, i_d};

endmodule

// File: rtl/ov7670_capture.sv
// Single-shot OV7670 frame grabber into frame buffer 1.
// Define CAPTURE_DECIMATE_EN for a VGA camera decimated 2:1 in both axes.
module ov7670_capture #(
    parameter int FRAME_W = cam_pkg::FRAME_W,
    parameter int FRAME_H = cam_pkg::FRAME_H
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           enable_capture,
    input  logic           cam_vsync,
    input  logic           cam_href,
    input  logic [7:0]     cam_data,
    output cam_pkg::addr_t wraddr_buf1,
    output cam_pkg::pix_t  dout_buf1,
    output logic           we_buf1,
    output logic           led_done,
    output logic           frame_err
);
    import cam_pkg::*;

    localparam addr_t NPIX_A = addr_t'(FRAME_W * FRAME_H);

    logic       vs_r, hr_r, r_hr_d;
    logic [7:0] d_r;
    state_t     r_state;
    addr_t      r_cnt;
    logic       r_ovf;
    logic [9:0] r_col, r_row;

    logic  w_cap, w_pix_done, w_keep, w_full, w_store, w_overrun;
    pix_t  w_pix;
    addr_t w_cnt_next;

    assign w_cap = (r_state == CAPTURE_ST);

    cam_pixel_assembler u_asm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_en       (w_cap),
        .i_hr       (hr_r),
        .i_d        (d_r),
        .o_pix_done (w_pix_done),
        .o_pix      (w_pix)
    );

`ifdef CAPTURE_DECIMATE_EN
    assign w_keep = ~r_col[0] & ~r_row[0];
`else
    assign w_keep = 1'b1;
`endif

    // A full buffer turns further eligible pixels into an overrun, not a write.
    assign w_full     = (r_cnt == NPIX_A);
    assign w_store    = w_pix_done & w_keep & ~w_full;
    assign w_overrun  = w_pix_done & w_keep & w_full;
    assign w_cnt_next = w_store ? r_cnt + 17'd1 : r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_r        <= 1'b0;
            hr_r        <= 1'b0;
            d_r         <= 8'd0;
            r_hr_d      <= 1'b0;
            r_state     <= IDLE_ST;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            wraddr_buf1 <= '0;
            dout_buf1   <= '0;
            we_buf1     <= 1'b0;
            led_done    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vs_r    <= cam_vsync;
            hr_r    <= cam_href;
            d_r     <= cam_data;
            r_hr_d  <= hr_r;
            we_buf1 <= 1'b0;
            case (r_state)
                IDLE_ST, DONE_ST: begin
                    if (enable_capture) begin
                        r_state     <= WAIT_VS_HIGH_ST;
                        led_done    <= 1'b0;
                        frame_err   <= 1'b0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        wraddr_buf1 <= '0;
                        r_col       <= '0;
                        r_row       <= '0;
                    end
                end
                WAIT_VS_HIGH_ST: begin
                    if (vs_r) begin
                        r_state <= WAIT_VS_LOW_ST;
                    end
                end
                WAIT_VS_LOW_ST: begin
                    // Entered only after vs_r was seen high, so the first low is the frame start.
                    if (!vs_r) begin
                        r_state <= CAPTURE_ST;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                CAPTURE_ST: begin
                    if (w_store) begin
                        we_buf1     <= 1'b1;
                        dout_buf1   <= w_pix;
                        wraddr_buf1 <= r_cnt;
                    end
                    r_cnt <= w_cnt_next;
                    if (w_overrun) begin
                        r_ovf <= 1'b1;
                    end
                    if (!hr_r) begin
                        r_col <= '0;
                    end else if (w_pix_done) begin
                        r_col <= r_col + 10'd1;
                    end
                    if (r_hr_d && !hr_r) begin
                        r_row <= r_row + 10'd1;
                    end
                    if (vs_r) begin
                        r_state   <= DONE_ST;
                        led_done  <= 1'b1;
                        frame_err <= (w_cnt_next != NPIX_A) | r_ovf | w_overrun;
                    end
                end
                default: r_state <= IDLE_ST;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a reduced frame; the reference model
// derives every expected write from the generated camera byte stream.
module tb_ov7670_capture;

    localparam int W    = 16;
    localparam int H    = 12;
    localparam int NPIX = W * H;
`ifdef CAPTURE_DECIMATE_EN
    localparam int DEC = 2;
`else
    localparam int DEC = 1;
`endif
    localparam int CW = W * DEC;
    localparam int CH = H * DEC;
    localparam int LB = 2 * CW;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_capture = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'd0;
    logic [16:0] wraddr_buf1;
    logic [11:0] dout_buf1;
    logic        we_buf1;
    logic        led_done;
    logic        frame_err;

    ov7670_capture #(.FRAME_W(W), .FRAME_H(H)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_capture (enable_capture),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .cam_data       (cam_data),
        .wraddr_buf1    (wraddr_buf1),
        .dout_buf1      (dout_buf1),
        .we_buf1        (we_buf1),
        .led_done       (led_done),
        .frame_err      (frame_err)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct packed {
        logic [16:0] a;
        logic [11:0] d;
    } wr_t;

    wr_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    bit         m_armed = 0, m_done = 0, m_err = 0, m_ovf = 0;
    int         m_cnt = 0;
    bit         lat_armed = 0;
    int         t_5c = 0;
    bit         prev_we = 0;
    logic [7:0] b [0:LB+3];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected write per strobe.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_we = 0;
        end else begin
            if (we_buf1) begin
                wr_t e;
                check("no_back_to_back_we", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none expected", wraddr_buf1, dout_buf1);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", {15'd0, wraddr_buf1}, {15'd0, e.a});
                    check("write_data", {20'd0, dout_buf1}, {20'd0, e.d});
                end
                if (lat_armed) begin
                    check("latency_after_5c", cyc - t_5c, 32'd2);
                    lat_armed = 0;
                end
            end
            prev_we = we_buf1;
        end
    end

    task automatic cyc_drive(input logic vs, input logic hr, input logic [7:0] d, input logic en);
        @(negedge clk_i);
        cam_vsync      = vs;
        cam_href       = hr;
        cam_data       = d;
        enable_capture = en;
    endtask

    // Inter-frame VSYNC pulse; checks the previous frame's status and optionally restarts.
    task automatic vs_high(input bit en_pulse);
        for (int i = 0; i < 8; i++) begin
            cyc_drive(1'b1, 1'b0, 8'($urandom), (i == 3) && en_pulse);
            if (i == 3) begin
                check("led_done", {31'd0, led_done}, {31'd0, m_done});
                check("frame_err", {31'd0, frame_err}, {31'd0, m_err});
                check("pending_writes", exp_q.size(), 32'd0);
                if (en_pulse) begin
                    m_armed = 1;
                    m_done  = 0;
                    m_err   = 0;
                end
            end
        end
    endtask

    task automatic vs_low_frame(input int nlines, input bit rand_len, input int odd_line,
                                input bit fixed_first, input int mid_en_line, input int rst_line);
        bit cap;
        int n;
        cap     = m_armed;
        m_armed = 0;
        if (cap) begin
            m_cnt = 0;
            m_ovf = 0;
        end
        for (int i = 0; i < 4; i++) cyc_drive(1'b0, 1'b0, 8'($urandom), 1'b0);
        for (int ln = 0; ln < nlines; ln++) begin
            if (ln == rst_line) begin
                cyc_drive(1'b0, 1'b0, 8'($urandom), 1'b0);
                rst_i = 1'b1;
                cyc_drive(1'b0, 1'b0, 8'($urandom), 1'b0);
                cyc_drive(1'b0, 1'b0, 8'($urandom), 1'b0);
                rst_i   = 1'b0;
                cap     = 0;
                m_done  = 0;
                m_err   = 0;
                m_armed = 0;
            end
            if (ln == mid_en_line) begin
                cyc_drive(1'b0, 1'b0, 8'($urandom), 1'b1);
                m_armed = 1;
            end
            if (rand_len) n = $urandom_range(LB + 3, 1);
            else if (ln == odd_line) n = LB - 1;
            else n = LB;
            for (int k = 0; k < n; k++) b[k] = 8'($urandom);
            if (fixed_first && ln == 0) begin
                b[0] = 8'h0A;
                b[1] = 8'h5C;
            end
            if (cap) begin
                for (int p = 0; p < n / 2; p++) begin
                    bit keep;
                    keep = (DEC == 1) || ((p % 2 == 0) && (ln % 2 == 0));
                    if (keep) begin
                        if (m_cnt < NPIX) begin
                            exp_q.push_back({17'(m_cnt), b[2*p][3:0], b[2*p+1]});
                            m_cnt++;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end
            end
            for (int k = 0; k < n; k++) begin
                cyc_drive(1'b0, 1'b1, b[k], 1'b0);
                if (fixed_first && ln == 0 && k == 1 && cap) begin
                    t_5c      = cyc;
                    lat_armed = 1;
                end
            end
            for (int i = 0; i < 6; i++) cyc_drive(1'b0, 1'b0, 8'($urandom), 1'b0);
        end
        if (cap) begin
            m_done = 1;
            m_err  = (m_cnt != NPIX) || m_ovf;
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) cyc_drive(1'b0, 1'b0, 8'd0, 1'b0);
        rst_i = 1'b0;
        cyc_drive(1'b0, 1'b0, 8'd0, 1'b0);
        check("reset_we", {31'd0, we_buf1}, 32'd0);
        check("reset_led_done", {31'd0, led_done}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_addr", {15'd0, wraddr_buf1}, 32'd0);
        check("reset_dout", {20'd0, dout_buf1}, 32'd0);

        vs_high(0); vs_low_frame(CH, 0, -1, 0, -1, -1);           // idle frames, no writes
        vs_high(0); vs_low_frame(CH, 0, -1, 0, 5, -1);            // enable mid-frame
        vs_high(0); vs_low_frame(CH, 0, -1, 1, -1, -1);           // first capture, 0x0A/0x5C lead
        vs_high(1); vs_low_frame(CH, 0, 4, 0, -1, -1);            // odd-length line
        vs_high(1); vs_low_frame(CH + DEC, 0, -1, 0, -1, -1);     // too many lines
        vs_high(1); vs_low_frame(CH - 1 + int'($urandom_range(2, 0)), 1, -1, 0, -1, -1);
        vs_high(1); vs_low_frame(CH, 0, -1, 0, -1, -1);           // clean full frame
        vs_high(1); vs_low_frame(CH, 0, -1, 0, -1, 3);            // reset mid-capture
        vs_high(0); vs_low_frame(CH, 0, -1, 0, -1, -1);           // idle after reset
        vs_high(0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
